debug_step_ctrl: RTL and testbench
==================================

DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive stable cycles needed to accept a new input level.
REQ-002 The block SHALL have parameter RUN_DIV, default 25000000, giving the cycle period between automatic steps in RUN.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port btn_step, input, 1, a raw asynchronous step push-button.
REQ-006 The block SHALL have port run_sw, input, 1, a raw asynchronous run/halt switch.
REQ-007 The block SHALL have port bp_en, input, 1, the breakpoint enable.
REQ-008 The block SHALL have port bp_addr, input, 16, the breakpoint PC value.
REQ-009 The block SHALL have port pc_in, input, 32, the current PC from the pipelined CPU.
REQ-010 The block SHALL have port sel_pc, input, 1; when 1 the display shows PC, when 0 it shows the register.
REQ-011 The block SHALL have port reg_sel, input, 5, the user register selector.
REQ-012 The block SHALL have port reg_data, input, 32, the register value read back from the CPU.
REQ-013 The block SHALL have port cpu_ce, output, 1, a one-cycle CPU advance enable.
REQ-014 The block SHALL have port reg_addr, output, 5, the mapped CPU register address.
REQ-015 The block SHALL have port disp_val, output, 16, the value sent to the seven-segment driver.
REQ-016 The block SHALL have port halted, output, 1, high when the CPU is not advancing.
REQ-017 The block SHALL have port step_cnt, output, 16, the count of cpu_ce pulses issued.

Function
REQ-018 btn_step and run_sw SHALL each pass through a 2-flop synchronizer before any use.
REQ-019 Each synchronized input SHALL have its own debounce counter; the debounced level flips only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any cycle of agreement.
REQ-020 A 0->1 transition of debounced btn_step SHALL produce a one-cycle step request; holding the button SHALL produce no further requests.
REQ-021 The FSM SHALL have states HALT, STEP, RUN and BREAK.
REQ-022 In HALT, debounced run_sw=1 SHALL go to RUN; otherwise a step request SHALL go to STEP; run wins if both occur in one cycle and the step request is dropped.
REQ-023 STEP SHALL assert cpu_ce for exactly one cycle, then always return to HALT.
REQ-024 In RUN, a divider SHALL count 0..RUN_DIV-1 and wrap; cpu_ce=1 in the cycle the divider equals RUN_DIV-1.
REQ-025 In RUN, the priority SHALL be: debounced run_sw=0 -> HALT, then breakpoint hit -> BREAK, then cpu_ce; no cpu_ce is issued in a cycle that leaves RUN.
REQ-026 A breakpoint hit SHALL be bp_en=1 and pc_in[15:0]==bp_addr, evaluated every RUN cycle, and SHALL be masked from entry into RUN until the first cpu_ce of that run.
REQ-027 The divider SHALL clear to 0 on every exit from RUN.
REQ-028 In BREAK, run_sw=0 SHALL go to HALT; otherwise a step request SHALL go to STEP; with run_sw held at 1 the FSM SHALL stay in BREAK.
REQ-029 halted SHALL be 1 in HALT and BREAK and 0 in STEP and RUN, decoded from the registered state.
REQ-030 step_cnt SHALL increment by 1 in each cycle cpu_ce=1 and wrap from 0xFFFF to 0x0000.
REQ-031 reg_addr SHALL be combinational: reg_sel<8 gives reg_sel+16; 8..15 gives reg_sel; 16..31 gives (reg_sel+8) mod 32.
REQ-032 disp_val SHALL be registered each cycle as sel_pc ? pc_in[15:0] : reg_data[15:0], with 1-cycle latency.

Reset
REQ-033 rst_n=0 SHALL, asynchronously, force state HALT, cpu_ce 0, halted 1, step_cnt 0, disp_val 0, and clear the divider, debounce counters, debounced levels and synchronizers to 0.
REQ-034 Reset asserted mid-STEP or mid-RUN SHALL drop cpu_ce immediately; after release, no step request is generated for a button already held until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=8)
REQ-035 Press btn_step for 20 cycles -> exactly one cpu_ce pulse, step_cnt=1, halted returns to 1.
REQ-036 A 3-cycle btn_step glitch -> no cpu_ce, step_cnt stays 0.
REQ-037 run_sw=1 for 80 cycles, bp_en=0 -> cpu_ce every 8th cycle, halted=0, step_cnt=9 or 10 depending on debounce alignment, checked exactly by the bench model.
REQ-038 RUN with bp_en=1, bp_addr=0x0010, pc_in changed to 0x0010 -> BREAK next cycle, no further cpu_ce; a step press -> one cpu_ce, then HALT; HALT->RUN with pc_in still 0x0010 -> no break before the first cpu_ce.
REQ-039 Sweep reg_sel over 0, 7, 8, 15, 16, 23, 24, 31 -> reg_addr 16, 23, 8, 15, 24, 31, 0, 7; sel_pc toggle -> disp_val follows one cycle later.
REQ-040 step_cnt preloaded to 0xFFFF via steps, plus one step -> 0x0000; rst_n pulsed low during RUN -> cpu_ce=0 and halted=1 without waiting for a clock edge.

Source files
------------

// File: rtl/debug_step_ctrl.sv
// Single-step / run / breakpoint controller for a pipelined CPU on a dev board.
// Raw button and switch are synchronized and debounced before they drive the FSM.
//
// state | meaning
// HALT  | CPU frozen, waiting for run switch or a step press
// STEP  | one cpu_ce pulse, then back to HALT
// RUN   | free-running, one cpu_ce every RUN_DIV cycles
// BREAK | stopped on breakpoint match; step or drop run to leave
module debug_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_step,
  input  logic        run_sw,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic [31:0] pc_in,
  input  logic        sel_pc,
  input  logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        cpu_ce,
  output logic [4:0]  reg_addr,
  output logic [15:0] disp_val,
  output logic        halted,
  output logic [15:0] step_cnt
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(RUN_DIV - 1);

  typedef enum logic [1:0] {HALT, STEP, RUN, BREAK} state_t;

  state_t          state, state_nxt;
  logic [1:0]      raw, sync1, sync2, deb;
  logic [DBW-1:0]  dcnt [2];
  logic [1:0]      sync_vld;
  logic            btn_deb_q, btn_armed, step_req, run_on;
  logic [DW-1:0]   div;
  logic            bp_live, bp_hit, stay_run;
  logic            unused_hi;

  assign raw       = {run_sw, btn_step};
  assign unused_hi = ^{pc_in[31:16], reg_data[31:16]};

  // bit 0: step button, bit 1: run switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // A button held through reset must be seen released before it may step again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_deb_q <= 1'b0;
      btn_armed <= 1'b0;
      sync_vld  <= '0;
    end else begin
      btn_deb_q <= deb[0];
      sync_vld  <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !sync2[0]) btn_armed <= 1'b1;
    end
  end

  assign step_req = deb[0] & ~btn_deb_q & btn_armed;
  assign run_on   = deb[1];
  assign bp_hit   = bp_en && (pc_in[15:0] == bp_addr) && bp_live;

  always_comb begin
    state_nxt = state;
    cpu_ce    = 1'b0;
    case (state)
      HALT: begin
        if (run_on)        state_nxt = RUN;
        else if (step_req) state_nxt = STEP;
      end
      STEP: begin
        cpu_ce    = 1'b1;
        state_nxt = HALT;
      end
      RUN: begin
        if (!run_on)              state_nxt = HALT;
        else if (bp_hit)          state_nxt = BREAK;
        else if (div == DIV_LAST) cpu_ce    = 1'b1;
      end
      BREAK: begin
        if (!run_on)       state_nxt = HALT;
        else if (step_req) state_nxt = STEP;
      end
      default: state_nxt = HALT;
    endcase
  end

  assign stay_run = (state == RUN) && (state_nxt == RUN);
  assign halted   = (state == HALT) || (state == BREAK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HALT;
      div      <= '0;
      bp_live  <= 1'b0;
      step_cnt <= '0;
      disp_val <= '0;
    end else begin
      state    <= state_nxt;
      div      <= stay_run ? ((div == DIV_LAST) ? '0 : div + 1'b1) : '0;
      bp_live  <= stay_run && (bp_live || cpu_ce);
      if (cpu_ce) step_cnt <= step_cnt + 16'd1;
      disp_val <= sel_pc ? pc_in[15:0] : reg_data[15:0];
    end
  end

  always_comb begin
    if (reg_sel < 5'd8)       reg_addr = reg_sel + 5'd16;
    else if (reg_sel < 5'd16) reg_addr = reg_sel;
    else                      reg_addr = reg_sel + 5'd8;
  end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: scoreboarded per-cycle cpu_ce/halted expectations,
// a vector table for register mapping and display, and a fast-divider instance for counter wrap.
module tb_debug_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_step = 1'b0, run_sw = 1'b0, bp_en = 1'b0, sel_pc = 1'b0;
  logic [15:0] bp_addr = '0;
  logic [31:0] pc_in = '0, reg_data = '0;
  logic [4:0]  reg_sel = '0;
  logic        cpu_ce, halted;
  logic [4:0]  reg_addr;
  logic [15:0] disp_val, step_cnt;

  logic        btn2 = 1'b0, run2 = 1'b0;
  logic        ce2, halted2;
  logic [4:0]  ra2;
  logic [15:0] disp2, cnt2;

  int checks = 0;
  int failures = 0;

  typedef struct {logic ce; logic hl;} exp_t;
  exp_t sbq[$];
  logic [15:0] dq[$];

  typedef struct {
    logic [4:0]  sel;
    logic        spc;
    logic [31:0] pc;
    logic [31:0] rd;
    logic [4:0]  ea;
    logic [15:0] ed;
  } vec_t;
  vec_t vecs[8];

  debug_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .run_sw(run_sw), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_in(pc_in), .sel_pc(sel_pc), .reg_sel(reg_sel),
    .reg_data(reg_data), .cpu_ce(cpu_ce), .reg_addr(reg_addr), .disp_val(disp_val),
    .halted(halted), .step_cnt(step_cnt)
  );

  debug_step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .btn_step(btn2), .run_sw(run2), .bp_en(1'b0),
    .bp_addr(16'h0000), .pc_in(pc_in), .sel_pc(sel_pc), .reg_sel(reg_sel),
    .reg_data(reg_data), .cpu_ce(ce2), .reg_addr(ra2), .disp_val(disp2),
    .halted(halted2), .step_cnt(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic ce, input logic hl);
    exp_t e;
    e.ce = ce;
    e.hl = hl;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input string tag, input int k);
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s[%0d] scoreboard empty actual=none required=entry", tag, k);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("%s[%0d]_ce", tag, k), cpu_ce, e.ce);
      chk($sformatf("%s[%0d]_halted", tag, k), halted, e.hl);
    end
  endtask

  initial begin
    vecs[0] = '{5'd0,  1'b0, 32'h0001_1111, 32'hF00D_0A0A, 5'd16, 16'h0A0A};
    vecs[1] = '{5'd7,  1'b1, 32'h0002_2222, 32'hBEEF_0B0B, 5'd23, 16'h2222};
    vecs[2] = '{5'd8,  1'b0, 32'h0003_3333, 32'h1234_0C0C, 5'd8,  16'h0C0C};
    vecs[3] = '{5'd15, 1'b1, 32'h0004_4444, 32'h0000_0D0D, 5'd15, 16'h4444};
    vecs[4] = '{5'd16, 1'b0, 32'h0005_5555, 32'hCAFE_0E0E, 5'd24, 16'h0E0E};
    vecs[5] = '{5'd23, 1'b1, 32'hDEAD_6666, 32'h0000_0F0F, 5'd31, 16'h6666};
    vecs[6] = '{5'd24, 1'b0, 32'h0007_7777, 32'h9999_ABCD, 5'd0,  16'hABCD};
    vecs[7] = '{5'd31, 1'b1, 32'h0008_8888, 32'h0000_1111, 5'd7,  16'h8888};

    // reset values, observed while reset is held
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ce", cpu_ce, 1'b0);
    chk("rst_halted", halted, 1'b1);
    chk("rst_step_cnt", step_cnt, 16'h0000);
    chk("rst_disp", disp_val, 16'h0000);
    reset_dut();

    // long press: one step, in cycle 7 after the press
    cyc();
    btn_step = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 20) btn_step = 1'b0;
      push_exp(k == 7, k != 7);
      sb_check("step", k);
      cyc();
    end
    chk("step_cnt_after_step", step_cnt, 16'd1);

    // 3-cycle glitch is rejected
    reset_dut();
    cyc();
    btn_step = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) btn_step = 1'b0;
      push_exp(1'b0, 1'b1);
      sb_check("glitch", k);
      cyc();
    end
    chk("step_cnt_after_glitch", step_cnt, 16'd0);

    // free run: RUN from cycle 7, cpu_ce at 14, 22, ...; async reset during a pulse
    reset_dut();
    bp_en = 1'b0;
    cyc();
    run_sw = 1'b1;
    for (int k = 0; k <= 86; k++) begin
      push_exp((k >= 14) && ((k - 14) % 8 == 0), k < 7);
      sb_check("run", k);
      if (k == 80) chk("run_step_cnt_80", step_cnt, 16'd9);
      if (k < 86) cyc();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ce", cpu_ce, 1'b0);
    chk("async_rst_halted", halted, 1'b1);
    chk("async_rst_step_cnt", step_cnt, 16'd0);
    run_sw = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // breakpoint, step out of BREAK, re-enter RUN with the hit still present
    reset_dut();
    bp_en   = 1'b1;
    bp_addr = 16'h0010;
    pc_in   = 32'h0000_0000;
    cyc();
    run_sw = 1'b1;
    for (int k = 0; k < 66; k++) begin
      if (k == 16) pc_in = 32'h0000_0010;
      if (k == 40) btn_step = 1'b1;
      if (k == 60) btn_step = 1'b0;
      push_exp((k == 14) || (k == 47) || (k == 56),
               (k < 7) || ((k >= 17) && (k <= 46)) || (k == 48) || (k >= 58));
      sb_check("bp", k);
      cyc();
    end
    chk("bp_step_cnt", step_cnt, 16'd3);
    run_sw = 1'b0;
    bp_en  = 1'b0;
    pc_in  = '0;

    // button held through reset must not step until released and pressed again
    btn_step = 1'b1;
    reset_dut();
    for (int k = 0; k < 25; k++) begin
      push_exp(1'b0, 1'b1);
      sb_check("held", k);
      cyc();
    end
    btn_step = 1'b0;
    repeat (12) cyc();
    btn_step = 1'b1;
    for (int k = 0; k < 12; k++) begin
      push_exp(k == 7, k != 7);
      sb_check("repress", k);
      cyc();
    end
    btn_step = 1'b0;
    chk("repress_step_cnt", step_cnt, 16'd1);

    // register map and display table
    for (int i = 0; i < 8; i++) begin
      reg_sel  = vecs[i].sel;
      sel_pc   = vecs[i].spc;
      pc_in    = vecs[i].pc;
      reg_data = vecs[i].rd;
      #1;
      chk($sformatf("reg_addr[%0d]", i), reg_addr, vecs[i].ea);
      dq.push_back(vecs[i].ed);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("disp[%0d]", i), disp_val, dq.pop_front());
    end

    // sel_pc toggle: old value until the next edge
    sel_pc   = 1'b1;
    pc_in    = 32'h0000_BEEF;
    reg_data = 32'h0000_C0DE;
    @(posedge clk);
    @(negedge clk);
    chk("disp_pc", disp_val, 16'hBEEF);
    sel_pc = 1'b0;
    #1;
    chk("disp_hold", disp_val, 16'hBEEF);
    @(posedge clk);
    @(negedge clk);
    chk("disp_reg", disp_val, 16'hC0DE);

    // step_cnt wrap on the fast instance: 65535 pulses, then one step
    reg_sel  = 5'd3;
    reg_data = 32'h0000_5A5A;
    reset_dut();
    cyc();
    run2 = 1'b1;
    repeat (100) cyc();
    chk("fast_cnt_100", cnt2, 16'd93);
    repeat (65436) cyc();
    run2 = 1'b0;
    repeat (10) cyc();
    chk("fast_cnt_ffff", cnt2, 16'hFFFF);
    chk("fast_halted", halted2, 1'b1);
    btn2 = 1'b1;
    repeat (20) cyc();
    btn2 = 1'b0;
    chk("fast_cnt_wrap", cnt2, 16'h0000);
    chk("fast_ce_idle", ce2, 1'b0);
    chk("fast_reg_addr", ra2, 5'd19);
    chk("fast_disp", disp2, 16'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
